// File: rtl/ffapuf_pkg.sv
// Shared definitions for the feed-forward arbiter PUF evaluation controller.
package ffapuf_pkg;

    localparam int CW_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_SETTLE = 3'd4,
        ST_SAMPLE = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Cycles spent on one evaluation: CLEAR + SETUP + LAUNCH + SETTLE + SAMPLE.
    function automatic int eval_len(input int clr_cycles, input int settle_cycles);
        return clr_cycles + settle_cycles + 3;
    endfunction

endpackage

// File: rtl/ffapuf_resp_sync.sv
// Two-flop synchronizer bringing the asynchronous PUF response into clk.
module ffapuf_resp_sync (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic s1_q, s2_q;
    logic s1_d, s2_d;

    // Next values of the synchronizer chain.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Chain flops, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!clr) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/ffapuf_eval_ctrl.sv
// Runs NUM_EVALS clear/launch/sample evaluations of one arbiter PUF line per
// challenge and returns the majority-voted response with its ones-count.
module ffapuf_eval_ctrl
    import ffapuf_pkg::*;
#(
    parameter int CW            = CW_DEF,
    parameter int NUM_EVALS     = 15,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          ch_valid,
    input  logic [CW-1:0] ch_data,
    output logic          ch_ready,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp,
    output logic [7:0]    rsp_ones,
    output logic          rsp_stable,
    output logic          busy,
    output logic [CW-1:0] puf_chal,
    output logic          puf_clr,
    output logic          puf_clk,
    input  logic          puf_r
);

    localparam int OW    = $clog2(NUM_EVALS + 1);
    localparam int EW    = $clog2(NUM_EVALS + 1);
    localparam int MAXC  = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EW-1:0]     eval_q, eval_d;
    logic [OW-1:0]     ones_q, ones_d, ones_sum;
    logic [CW-1:0]     chal_q, chal_d;
    logic              clr_q, clr_d;
    logic              clk_q, clk_d;
    logic              vld_q, vld_d;
    logic              rsp_q, rsp_d;
    logic [7:0]        rones_q, rones_d;
    logic              stab_q, stab_d;
    logic              r_sync;

    ffapuf_resp_sync u_sync (
        .clk (clk),
        .clr (clr),
        .d   (puf_r),
        .q   (r_sync)
    );

    // Next-state, counters and the registered PUF/result outputs derived from it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        eval_d   = eval_q;
        ones_d   = ones_q;
        chal_d   = chal_q;
        rsp_d    = rsp_q;
        rones_d  = rones_q;
        stab_d   = stab_q;
        ones_sum = ones_q + OW'(r_sync);
        case (state_q)
            ST_IDLE: if (ch_valid) begin
                chal_d  = ch_data;
                eval_d  = '0;
                ones_d  = '0;
                cnt_d   = '0;
                state_d = ST_CLEAR;
            end
            ST_CLEAR: if (cnt_q == CNT_W'(CLR_CYCLES - 1)) begin
                cnt_d   = '0;
                state_d = ST_SETUP;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            ST_SETUP:  state_d = ST_LAUNCH;
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                cnt_d   = '0;
                state_d = ST_SAMPLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            ST_SAMPLE: begin
                ones_d = ones_sum;
                eval_d = eval_q + EW'(1);
                cnt_d  = '0;
                if (eval_d == EW'(NUM_EVALS)) begin
                    // Result is frozen here and held until the next DONE.
                    rsp_d   = (ones_sum > OW'(NUM_EVALS / 2));
                    rones_d = 8'(ones_sum);
                    stab_d  = (ones_sum == '0) || (ones_sum == OW'(NUM_EVALS));
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_DONE: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Outputs follow the state being entered so they are glitch-free flops.
        clr_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR) || (state_d == ST_DONE);
        clk_d = (state_d == ST_LAUNCH);
        vld_d = (state_d == ST_DONE);
    end

    // FSM, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            eval_q  <= '0;
            ones_q  <= '0;
            chal_q  <= '0;
            clr_q   <= 1'b1;
            clk_q   <= 1'b0;
            vld_q   <= 1'b0;
            rsp_q   <= 1'b0;
            rones_q <= '0;
            stab_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            eval_q  <= eval_d;
            ones_q  <= ones_d;
            chal_q  <= chal_d;
            clr_q   <= clr_d;
            clk_q   <= clk_d;
            vld_q   <= vld_d;
            rsp_q   <= rsp_d;
            rones_q <= rones_d;
            stab_q  <= stab_d;
        end
    end

    assign ch_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_valid  = vld_q;
    assign rsp        = rsp_q;
    assign rsp_ones   = rones_q;
    assign rsp_stable = stab_q;
    assign puf_chal   = chal_q;
    assign puf_clr    = clr_q;
    assign puf_clk    = clk_q;

endmodule

// File: doc/ffapuf_eval_ctrl.md
Name: ffapuf_eval_ctrl

Overview:
Sequencer for one 32-bit feed-forward arbiter PUF line. It accepts a challenge over a valid/ready handshake and runs NUM_EVALS evaluations of the line. Each evaluation clears the line, launches it with a single clock edge, then samples the response through a synchronizer. It majority-votes the samples and returns the response, its ones-count and a stability flag over a valid/ready handshake. It sits between the challenge source (host/UART logic) and the ffapuf line instance.

Parameters:
CW, 32, challenge width; must match the PUF line.
NUM_EVALS, 15, evaluations per challenge; odd, 1..255.
CLR_CYCLES, 2, cycles puf_clr is held high per evaluation; >=1.
SETTLE_CYCLES, 8, cycles from launch to sample; >=3 to cover the synchronizer.

Ports:
clk  in  1  system clock; all logic on the rising edge.
clr  in  1  synchronous, active-low reset.
ch_valid  in  1  challenge offered.
ch_data  in  CW  challenge value.
ch_ready  out  1  controller can accept a challenge.
rsp_valid  out  1  result available.
rsp_ready  in  1  result consumed.
rsp  out  1  majority-voted response.
rsp_ones  out  8  count of samples equal to 1.
rsp_stable  out  1  all samples agree.
busy  out  1  high in any state other than IDLE.
puf_chal  out  CW  challenge driven to the PUF line.
puf_clr  out  1  active-high clear to the PUF line.
puf_clk  out  1  launch clock to the PUF line.
puf_r  in  1  raw PUF response; asynchronous to clk.

Behaviour:
- States: IDLE, CLEAR, SETUP, LAUNCH, SETTLE, SAMPLE, DONE.
- Reset (clr=0 at an edge), including mid-operation:
  - state goes to IDLE; the evaluation and ones counters clear.
  - puf_chal=0, puf_clr=1, puf_clk=0, rsp_valid=0, rsp=0, rsp_ones=0, rsp_stable=0.
  - The synchronizer flops clear.
- IDLE: ch_ready=1, puf_clr=1.
  - On ch_valid&ch_ready: latch ch_data into puf_chal, clear counters, go to CLEAR.
- CLEAR: puf_clr=1 for exactly CLR_CYCLES cycles, then SETUP.
- SETUP: 1 cycle; puf_clr=0, puf_clk=0; challenge has been stable since the accept.
- LAUNCH: 1 cycle with puf_clk=1. puf_clk is 0 in every other state and is driven from a flop.
- SETTLE: SETTLE_CYCLES cycles with puf_clk=0 and puf_clr=0.
- SAMPLE: 1 cycle.
  - Add the synchronized response to the ones counter.
  - Increment the evaluation counter.
  - If the counter reaches NUM_EVALS, go to DONE; otherwise go to CLEAR.
- Per-evaluation length E = CLR_CYCLES+SETTLE_CYCLES+3 cycles.
  - rsp_valid first becomes high NUM_EVALS*E rising edges after the accepting edge.
  - With defaults: 195 edges.
- DONE: rsp_valid=1, puf_clr=1.
  - rsp = (ones > NUM_EVALS/2).
  - rsp_stable = (ones==0) or (ones==NUM_EVALS).
  - rsp_ones = ones, zero-extended to 8 bits.
  - All result outputs are registered and held stable until rsp_valid&rsp_ready. On that edge go to IDLE and drop rsp_valid.
  - rsp/rsp_ones/rsp_stable keep their values until the next DONE.
- ch_ready is 0 in every non-IDLE state, including the DONE cycle where rsp_ready=1. No same-cycle response/challenge overlap; the earliest next accept is the IDLE cycle that follows.
- ch_valid and ch_data changes while busy are ignored; puf_chal changes only on an accept or a reset.
- Ones counter: width $clog2(NUM_EVALS+1); it never wraps because it saturates at NUM_EVALS by construction.
- puf_r passes through a 2-flop synchronizer. The SAMPLE value therefore reflects puf_r from at least 2 cycles earlier, i.e. within SETTLE.

Decomposition:
- Shared package ffapuf_pkg:
  - state encoding localparams;
  - CW default;
  - the E formula as a function, also used by the bench.
- One sub-module, ffapuf_resp_sync: 2-flop synchronizer with synchronous active-low reset to 0.
- The FSM and counters stay in ffapuf_eval_ctrl.

Test Plan:
- Reset: drive clr=0 for 3 cycles during SETTLE of evaluation 5 -> next cycle shows IDLE, ch_ready=1, puf_clr=1, puf_clk=0, rsp_valid=0, puf_chal=0. A new challenge then completes normally.
- Stuck-at-1 model, challenge 0xDEADBEEF -> puf_chal=0xDEADBEEF throughout; exactly 15 one-cycle puf_clk pulses; rsp_valid 195 edges after accept; rsp=1, rsp_ones=15, rsp_stable=1.
- Model returns 1 on 8 of 15 launches -> rsp=1, rsp_ones=8, rsp_stable=0. Model returns 1 on 7 of 15 -> rsp=0, rsp_ones=7, rsp_stable=0.
- Backpressure: rsp_ready=0 for 20 cycles in DONE with ch_valid=1 and ch_data=0x12345678 -> rsp fields constant and ch_ready=0 throughout. Raise rsp_ready -> IDLE next cycle, then accept 0x12345678.
- Waveform timing per evaluation: puf_clr high exactly 2 cycles, then exactly 1 cycle low before the puf_clk rise, puf_clk high exactly 1 cycle, and 8 SETTLE cycles before SAMPLE. Toggling ch_data while busy never alters puf_chal.
